// File: rtl/pc_register.sv
// Program counter with a boot/run/halt sequencer for the 8-bit unicycle MIPS datapath.
// Define PC_RAS_EN to add a circular return-address stack for Call/Ret.
module pc_register #(
  parameter logic [7:0]  RESET_VECTOR = 8'h00,
  parameter int unsigned RAS_DEPTH    = 4
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Stall,
  input  logic       Halt,
  input  logic       Resume,
  input  logic       Branch,
  input  logic [7:0] BranchOffset,
  input  logic       Jump,
  input  logic [7:0] JumpTarget,
  input  logic       Call,
  input  logic       Ret,
  output logic [7:0] PCResult,
  output logic       Valid,
  output logic       Halted,
  output logic       RasErr
);

  typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d, pc_inc;
  logic       push, pop, ret_en;
  logic [7:0] pop_pc;

  assign pc_inc = pc_q + 8'd1;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        if (!Stall) begin
          if (Halt) begin
            state_d = StHalt;
          end else if (ret_en) begin
            pop  = 1'b1;
            pc_d = pop_pc;
          end else if (Call) begin
            push = 1'b1;
            pc_d = JumpTarget;
          end else if (Jump) begin
            pc_d = JumpTarget;
          end else if (Branch) begin
            pc_d = pc_inc + BranchOffset;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      StHalt: begin
        if (Resume) begin
          state_d = StRun;
          pc_d    = pc_inc;
        end
      end
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= StBoot;
      pc_q    <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign PCResult = pc_q;
  assign Valid    = (state_q == StRun);
  assign Halted   = (state_q == StHalt);

`ifdef PC_RAS_EN
  localparam int unsigned PtrW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PtrW:0] Full = (PtrW + 1)'(RAS_DEPTH);

  logic [7:0]      ras_q [RAS_DEPTH];
  logic [PtrW-1:0] ptr_q, ptr_d, ptr_dec;
  logic [PtrW:0]   cnt_q, cnt_d;
  logic            err_q, err_d, empty;

  // ptr_q is the next free slot; pushes past Full wrap onto the oldest entry.
  assign ret_en  = Ret;
  assign empty   = (cnt_q == '0);
  assign ptr_dec = ptr_q - PtrW'(1);
  assign pop_pc  = empty ? pc_inc : ras_q[ptr_dec];

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (pop) begin
      if (empty) begin
        err_d = 1'b1;
      end else begin
        ptr_d = ptr_dec;
        cnt_d = cnt_q - (PtrW + 1)'(1);
      end
    end else if (push) begin
      ptr_d = ptr_q + PtrW'(1);
      if (cnt_q == Full) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + (PtrW + 1)'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      ras_q[ptr_q] <= pc_inc;
    end
  end

  assign RasErr = err_q;
`else
  logic unused_ras;

  assign ret_en     = 1'b0;
  assign pop_pc     = pc_inc;
  assign RasErr     = 1'b0;
  assign unused_ras = ^{Ret, push, pop, RAS_DEPTH};
`endif

endmodule

// File: tb/tb_pc_register.sv
// Bench for pc_register: directed vector table, hand-written reset/halt/stack sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_pc_register;

  localparam logic [7:0]  RV    = 8'h10;
  localparam int unsigned Depth = 4;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       Stall = 1'b0, Halt = 1'b0, Resume = 1'b0, Branch = 1'b0;
  logic [7:0] BranchOffset = 8'h00;
  logic       Jump = 1'b0;
  logic [7:0] JumpTarget = 8'h00;
  logic       Call = 1'b0, Ret = 1'b0;
  logic [7:0] PCResult;
  logic       Valid, Halted, RasErr;

  int checks = 0;
  int errors = 0;

  pc_register #(
    .RESET_VECTOR (RV),
    .RAS_DEPTH    (Depth)
  ) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .Stall        (Stall),
    .Halt         (Halt),
    .Resume       (Resume),
    .Branch       (Branch),
    .BranchOffset (BranchOffset),
    .Jump         (Jump),
    .JumpTarget   (JumpTarget),
    .Call         (Call),
    .Ret          (Ret),
    .PCResult     (PCResult),
    .Valid        (Valid),
    .Halted       (Halted),
    .RasErr       (RasErr)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       stall, halt, resume, branch;
    logic [7:0] off;
    logic       jump;
    logic [7:0] tgt;
    logic       call, ret;
    logic [7:0] e_pc;
    logic       e_valid, e_halted;
  } vec_t;

  vec_t vecs[$];

  // Reference model: mode 0=boot, 1=run, 2=halt; stack holds return addresses, newest last.
  int         m_mode;
  logic [7:0] m_pc;
  logic [7:0] m_stack[$];
  logic       m_err;

  function automatic vec_t mk(input logic stall, input logic halt, input logic resume,
                              input logic branch, input logic [7:0] off, input logic jump,
                              input logic [7:0] tgt, input logic call, input logic ret,
                              input logic [7:0] e_pc, input logic e_valid,
                              input logic e_halted);
    vec_t v;
    v.stall = stall; v.halt = halt; v.resume = resume; v.branch = branch; v.off = off;
    v.jump = jump; v.tgt = tgt; v.call = call; v.ret = ret;
    v.e_pc = e_pc; v.e_valid = e_valid; v.e_halted = e_halted;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic stall, input logic halt, input logic resume,
                       input logic branch, input logic [7:0] off, input logic jump,
                       input logic [7:0] tgt, input logic call, input logic ret);
    Stall = stall; Halt = halt; Resume = resume; Branch = branch; BranchOffset = off;
    Jump = jump; JumpTarget = tgt; Call = call; Ret = ret;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_pc   = RV;
    m_stack.delete();
    m_err  = 1'b0;
  endtask

  task automatic model_step();
    logic [7:0] nxt;
    nxt = m_pc + 8'd1;
    case (m_mode)
      0: m_mode = 1;
      1: begin
        if (Stall) begin
        end else if (Halt) begin
          m_mode = 2;
`ifdef PC_RAS_EN
        end else if (Ret) begin
          if (m_stack.size() == 0) begin
            m_err = 1'b1;
            m_pc  = nxt;
          end else begin
            m_pc = m_stack.pop_back();
          end
        end else if (Call) begin
          if (m_stack.size() == Depth) begin
            void'(m_stack.pop_front());
            m_err = 1'b1;
          end
          m_stack.push_back(nxt);
          m_pc = JumpTarget;
`endif
        end else if (Call || Jump) begin
          m_pc = JumpTarget;
        end else if (Branch) begin
          m_pc = nxt + BranchOffset;
        end else begin
          m_pc = nxt;
        end
      end
      default: begin
        if (Resume) begin
          m_mode = 1;
          m_pc   = nxt;
        end
      end
    endcase
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".pc"}, PCResult, m_pc);
    chk({tag, ".valid"}, {7'd0, Valid}, {7'd0, m_mode == 1});
    chk({tag, ".halted"}, {7'd0, Halted}, {7'd0, m_mode == 2});
    chk({tag, ".raserr"}, {7'd0, RasErr}, {7'd0, m_err});
  endtask

  // Assert reset mid-cycle, confirm it acts immediately, release away from the edge.
  task automatic areset(input string tag);
    @(negedge Clk);
    #2;
    Rst_n = 1'b0;
    idle();
    #1;
    chk({tag, ".rst_pc"}, PCResult, RV);
    chk({tag, ".rst_valid"}, {7'd0, Valid}, 8'h00);
    chk({tag, ".rst_halted"}, {7'd0, Halted}, 8'h00);
    chk({tag, ".rst_raserr"}, {7'd0, RasErr}, 8'h00);
    @(negedge Clk);
    Rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    vec_t v;
    logic [7:0] ret_exp;
`ifdef PC_RAS_EN
    ret_exp = 8'h06;
`else
    ret_exp = 8'h81;
`endif
    //          st ha re br off    jp tgt    ca rt  pc     v  h
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h10, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h11, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h12, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 8'h00, 1, 8'h40, 0, 0, 8'h12, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 8'h05, 1, 8'h40, 0, 0, 8'h40, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 8'hF0, 0, 8'h00, 0, 0, 8'h31, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 1, 8'hFF, 0, 0, 8'hFF, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 1, 8'h02, 0, 0, 8'h02, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 8'hF0, 0, 8'h00, 0, 0, 8'hF3, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 1, 8'h20, 0, 0, 8'h20, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 1, 8'h55, 0, 0, 8'h20, 0, 1));
    for (int i = 0; i < 4; i++) begin
      vecs.push_back(mk(1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h20, 0, 1));
    end
    vecs.push_back(mk(1, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 8'h21, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h21, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 1, 8'h05, 0, 0, 8'h05, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 8'h80, 1, 0, 8'h80, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 1, ret_exp, 1, 0));

    // Reset sequencing: cycle 0 shows the reset vector, not yet valid.
    Rst_n = 1'b0;
    idle();
    #12;
    @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    chk("boot.pc", PCResult, RV);
    chk("boot.valid", {7'd0, Valid}, 8'h00);
    chk("boot.halted", {7'd0, Halted}, 8'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v.stall, v.halt, v.resume, v.branch, v.off, v.jump, v.tgt, v.call, v.ret);
      tick();
      chk($sformatf("vec%0d.pc", i), PCResult, v.e_pc);
      chk($sformatf("vec%0d.valid", i), {7'd0, Valid}, {7'd0, v.e_valid});
      chk($sformatf("vec%0d.halted", i), {7'd0, Halted}, {7'd0, v.e_halted});
      chk($sformatf("vec%0d.raserr", i), {7'd0, RasErr}, 8'h00);
    end
    idle();

    areset("run");
    tick();
    chk("rerun.pc", PCResult, RV);
    chk("rerun.valid", {7'd0, Valid}, 8'h01);
    drive(0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0);
    tick();
    chk("halt2.halted", {7'd0, Halted}, 8'h01);
    idle();
    tick();
    areset("halt");
    tick();

`ifdef PC_RAS_EN
    // Five nested calls overflow a four-deep stack; the oldest link (01) is lost.
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, 0, 8'h00, 1, 8'(k), 0, 0);
      tick();
      drive(0, 0, 0, 0, 8'h00, 0, 8'h80, 1, 0);
      tick();
      chk($sformatf("call%0d.pc", k), PCResult, 8'h80);
      chk($sformatf("call%0d.raserr", k), {7'd0, RasErr}, {7'd0, k == 4});
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 1);
      tick();
      chk($sformatf("ret%0d.pc", k), PCResult, 8'(5 - k));
    end
    drive(0, 0, 0, 0, 8'h00, 0, 8'h80, 1, 1);
    tick();
    chk("callret.pc", PCResult, 8'h03);
    areset("ras");
    tick();
    drive(0, 0, 0, 0, 8'h00, 1, 8'h30, 0, 0);
    tick();
    drive(0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 1);
    tick();
    chk("underflow.pc", PCResult, 8'h31);
    chk("underflow.raserr", {7'd0, RasErr}, 8'h01);
    idle();
    tick();
    chk("sticky.raserr", {7'd0, RasErr}, 8'h01);
`else
    drive(0, 0, 0, 0, 8'h00, 1, 8'h05, 0, 0);
    tick();
    drive(0, 0, 0, 0, 8'h00, 0, 8'h80, 1, 0);
    tick();
    chk("nocall.pc", PCResult, 8'h80);
    drive(0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 1);
    tick();
    chk("noret.pc", PCResult, 8'h81);
    drive(0, 0, 0, 1, 8'h10, 0, 8'h00, 0, 1);
    tick();
    chk("noret_br.pc", PCResult, 8'h92);
    chk("noret.raserr", {7'd0, RasErr}, 8'h00);
`endif

    // Randomized traffic against the reference model.
    for (int r = 0; r < 3; r++) begin
      areset($sformatf("rnd%0d", r));
      for (int c = 0; c < 600; c++) begin
        drive(($urandom % 8) == 0, ($urandom % 20) == 0, ($urandom % 3) == 0,
              ($urandom % 4) == 0, 8'($urandom), ($urandom % 6) == 0, 8'($urandom),
              ($urandom % 6) == 0, ($urandom % 6) == 0);
        model_step();
        tick();
        check_model($sformatf("rnd%0d.%0d", r, c));
      end
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
